// File: rtl/colour_centroid_tracker_pkg.sv
// Shared types, FSM encodings and width helpers for the colour centroid tracker.
// Optional bbox outputs are enabled with CENTROID_BBOX_EN.
package centroid_pkg;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

    typedef logic       pix_state_e;
    typedef logic [2:0] math_state_e;

    localparam pix_state_e PX_SYNC  = 1'b0;
    localparam pix_state_e PX_ACCUM = 1'b1;

    localparam math_state_e M_IDLE    = 3'd0;
    localparam math_state_e M_DIV_MX  = 3'd1;
    localparam math_state_e M_DIV_MY  = 3'd2;
    localparam math_state_e M_SCL_X   = 3'd3;
    localparam math_state_e M_SCL_Y   = 3'd4;
    localparam math_state_e M_PUBLISH = 3'd5;

    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    function automatic int sum_w(int w, int h);
        int sx;
        int sy;
        sx = w * (w - 1) / 2 * h;
        sy = h * (h - 1) / 2 * w;
        return $clog2(((sx > sy) ? sx : sy) + 1);
    endfunction

    function automatic int cnt_w(int w, int h);
        return $clog2(w * h + 1);
    endfunction

    function automatic int head_w(int fov);
        return $clog2(fov) + 1;
    endfunction

    // Margin is target minus the larger of the other two, as 5-bit signed.
    function automatic logic detect(logic [11:0] p, logic [1:0] ch,
                                    logic [3:0] thr);
        logic [3:0] r, g, b, t, a, c, m;
        r = p[R_LSB+:4];
        g = p[G_LSB+:4];
        b = p[B_LSB+:4];
        case (channel_e'(ch))
            CH_G:    begin t = g; a = r; c = b; end
            CH_B:    begin t = b; a = r; c = g; end
            default: begin t = r; a = g; c = b; end
        endcase
        m = (a > c) ? a : c;
        return ($signed({1'b0, t}) - $signed({1'b0, m}))
               >= $signed({1'b0, thr});
    endfunction

endpackage

// File: rtl/colour_centroid_tracker_if.sv
// Pixel stream and result handshake bundle for the colour centroid tracker.
// master = pixel source / result consumer, slave = tracker.
interface colour_centroid_tracker_if
    import centroid_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int FOV          = 25,
    parameter int VFOV         = 19
);
    localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam int CW = cnt_w(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int HW = head_w(FOV);
    localparam int VW = head_w(VFOV);

    logic                 pix_valid;
    logic [AW-1:0]        pix_addr;
    logic [11:0]          pix_data;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [HW-1:0] heading;
    logic signed [VW-1:0] elevation;
    logic [CW-1:0]        pix_count;
    logic                 overrun;

    modport master (
        output pix_valid, pix_addr, pix_data, res_ready,
        input  res_valid, heading, elevation, pix_count, overrun
    );

    modport slave (
        input  pix_valid, pix_addr, pix_data, res_ready,
        output res_valid, heading, elevation, pix_count, overrun
    );
endinterface

// File: rtl/colour_centroid_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done pulses for one cycle with the quotient valid on quotient.
module seq_divider #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic [N:0]    trial;
    logic [N:0]    diff;
    logic          ge;

    assign trial    = {rem, quo[N-1]};
    assign diff     = trial - {1'b0, dvs};
    assign ge       = trial >= {1'b0, dvs};
    assign quotient = quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= '0;
                quo  <= dividend;
                dvs  <= divisor;
                cnt  <= CW'(N);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= ge ? diff[N-1:0] : trial[N-1:0];
                quo <= {quo[N-2:0], ge};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/colour_centroid_tracker.sv
// Per-frame colour centroid tracker: heading/elevation of pixels dominant in one channel.
// Define CENTROID_BBOX_EN to add bounding-box outputs.
module colour_centroid_tracker
    import centroid_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int FOV          = 25,
    parameter int VFOV         = 19,
    parameter int MIN_PIXELS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    colour_centroid_tracker_if.slave bus,
    input  logic [1:0] cfg_channel,
    input  logic [3:0] cfg_threshold,
    output logic       sync_err
`ifdef CENTROID_BBOX_EN
    ,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  bbox_xmin,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  bbox_xmax,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] bbox_ymin,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] bbox_ymax
`endif
);
    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int XW   = $clog2(IMAGE_WIDTH);
    localparam int YW   = $clog2(IMAGE_HEIGHT);
    localparam int SW   = sum_w(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int CW   = cnt_w(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int HW   = head_w(FOV);
    localparam int VW   = head_w(VFOV);

    pix_state_e           pst;
    logic [ADDR_BITS-1:0] exp_addr;
    logic [XW-1:0]        col;
    logic [YW-1:0]        row;
    logic [1:0]           lat_ch;
    logic [3:0]           lat_thr;
    logic [SW-1:0]        sum_x, sum_y;
    logic [CW-1:0]        cnt;

    logic          accept, misseq, det, last;
    logic [1:0]    ch;
    logic [3:0]    thr;
    logic [SW-1:0] nsx, nsy;
    logic [CW-1:0] ncnt;

    // In SYNC the counters are already zero, so address 0 is the only match.
    assign accept = bus.pix_valid && (bus.pix_addr == exp_addr);
    assign misseq = bus.pix_valid && (pst == PX_ACCUM)
                    && (bus.pix_addr != exp_addr);
    assign ch     = (pst == PX_SYNC) ? cfg_channel : lat_ch;
    assign thr    = (pst == PX_SYNC) ? cfg_threshold : lat_thr;
    assign det    = accept && detect(bus.pix_data, ch, thr);
    assign last   = accept && (exp_addr == ADDR_BITS'(NPIX - 1));
    assign nsx    = sum_x + (det ? SW'(col) : '0);
    assign nsy    = sum_y + (det ? SW'(row) : '0);
    assign ncnt   = cnt + (det ? CW'(1) : '0);

`ifdef CENTROID_BBOX_EN
    logic [XW-1:0] lx0, lx1, nx0, nx1, sx0, sx1;
    logic [YW-1:0] ly0, ly1, ny0, ny1, sy0, sy1;
    assign nx0 = (det && col < lx0) ? col : lx0;
    assign nx1 = (det && col > lx1) ? col : lx1;
    assign ny0 = (det && row < ly0) ? row : ly0;
    assign ny1 = (det && row > ly1) ? row : ly1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst      <= PX_SYNC;
            exp_addr <= '0;
            col      <= '0;
            row      <= '0;
            lat_ch   <= '0;
            lat_thr  <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            cnt      <= '0;
            sync_err <= 1'b0;
`ifdef CENTROID_BBOX_EN
            lx0 <= '1; lx1 <= '0; ly0 <= '1; ly1 <= '0;
`endif
        end else begin
            sync_err <= misseq;
            if (misseq || last) begin
                pst      <= PX_SYNC;
                exp_addr <= '0;
                col      <= '0;
                row      <= '0;
                sum_x    <= '0;
                sum_y    <= '0;
                cnt      <= '0;
`ifdef CENTROID_BBOX_EN
                lx0 <= '1; lx1 <= '0; ly0 <= '1; ly1 <= '0;
`endif
            end else if (accept) begin
                if (pst == PX_SYNC) begin
                    pst     <= PX_ACCUM;
                    lat_ch  <= cfg_channel;
                    lat_thr <= cfg_threshold;
                end
                exp_addr <= exp_addr + ADDR_BITS'(1);
                sum_x    <= nsx;
                sum_y    <= nsy;
                cnt      <= ncnt;
                if (col == XW'(IMAGE_WIDTH - 1)) begin
                    col <= '0;
                    row <= row + YW'(1);
                end else begin
                    col <= col + XW'(1);
                end
`ifdef CENTROID_BBOX_EN
                lx0 <= nx0; lx1 <= nx1; ly0 <= ny0; ly1 <= ny1;
`endif
            end
        end
    end

    math_state_e          mst;
    logic                 go;
    logic [SW-1:0]        s_sx, s_sy, mean_x, mean_y;
    logic [CW-1:0]        s_cnt;
    logic signed [HW-1:0] hx;
    logic signed [VW-1:0] hy;
    logic                 dv_start, dv_busy, dv_done;
    logic [SW-1:0]        dv_a, dv_b, dv_q;
    logic                 math_busy, enough, drop, hs;

    assign math_busy = go || (mst != M_IDLE) || dv_busy;
    assign enough    = s_cnt >= CW'(MIN_PIXELS);
    assign drop      = last && math_busy;
    assign hs        = bus.res_valid && bus.res_ready;

    always_comb begin
        dv_start = 1'b0;
        dv_a     = s_sx;
        dv_b     = SW'(s_cnt);
        case (mst)
            M_IDLE:   dv_start = go && enough;
            M_DIV_MX: begin
                dv_start = dv_done;
                dv_a     = s_sy;
            end
            M_DIV_MY: begin
                dv_start = dv_done;
                dv_a     = mean_x * SW'(FOV);
                dv_b     = SW'(IMAGE_WIDTH - 1);
            end
            M_SCL_X:  begin
                dv_start = dv_done;
                dv_a     = mean_y * SW'(VFOV);
                dv_b     = SW'(IMAGE_HEIGHT - 1);
            end
            default:  dv_start = 1'b0;
        endcase
    end

    seq_divider #(.N(SW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (dv_start),
        .dividend (dv_a),
        .divisor  (dv_b),
        .busy     (dv_busy),
        .done     (dv_done),
        .quotient (dv_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst    <= M_IDLE;
            go     <= 1'b0;
            s_sx   <= '0;
            s_sy   <= '0;
            s_cnt  <= '0;
            mean_x <= '0;
            mean_y <= '0;
            hx     <= '1;
            hy     <= '1;
`ifdef CENTROID_BBOX_EN
            sx0 <= '1; sx1 <= '0; sy0 <= '1; sy1 <= '0;
`endif
        end else begin
            // A new frame is only snapshotted while the math side is idle.
            if (last && !math_busy) begin
                go    <= 1'b1;
                s_sx  <= nsx;
                s_sy  <= nsy;
                s_cnt <= ncnt;
`ifdef CENTROID_BBOX_EN
                sx0 <= nx0; sx1 <= nx1; sy0 <= ny0; sy1 <= ny1;
`endif
            end
            case (mst)
                M_IDLE: if (go) begin
                    go <= 1'b0;
                    if (enough) begin
                        mst <= M_DIV_MX;
                    end else begin
                        hx  <= '1;
                        hy  <= '1;
                        mst <= M_PUBLISH;
                    end
                end
                M_DIV_MX: if (dv_done) begin
                    mean_x <= dv_q;
                    mst    <= M_DIV_MY;
                end
                M_DIV_MY: if (dv_done) begin
                    mean_y <= dv_q;
                    mst    <= M_SCL_X;
                end
                M_SCL_X: if (dv_done) begin
                    hx  <= HW'(dv_q);
                    mst <= M_SCL_Y;
                end
                M_SCL_Y: if (dv_done) begin
                    hy  <= VW'(dv_q);
                    mst <= M_PUBLISH;
                end
                default: mst <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_valid <= 1'b0;
            bus.heading   <= '1;
            bus.elevation <= '1;
            bus.pix_count <= '0;
            bus.overrun   <= 1'b0;
`ifdef CENTROID_BBOX_EN
            bbox_xmin <= '1; bbox_xmax <= '0;
            bbox_ymin <= '1; bbox_ymax <= '0;
`endif
        end else begin
            bus.overrun <= (bus.overrun && !hs) || drop
                           || ((mst == M_PUBLISH) && bus.res_valid && !bus.res_ready);
            if (mst == M_PUBLISH) begin
                bus.res_valid <= 1'b1;
                bus.heading   <= hx;
                bus.elevation <= hy;
                bus.pix_count <= s_cnt;
`ifdef CENTROID_BBOX_EN
                bbox_xmin <= enough ? sx0 : '1;
                bbox_xmax <= enough ? sx1 : '0;
                bbox_ymin <= enough ? sy0 : '1;
                bbox_ymax <= enough ? sy1 : '0;
`endif
            end else if (hs) begin
                bus.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_colour_centroid_tracker.sv
// Directed bench for colour_centroid_tracker on a reduced 32x8 frame.
// Expected values are hand-computed for W=32, H=8, FOV=25, VFOV=19.
module tb_colour_centroid_tracker;
    localparam int W  = 32;
    localparam int H  = 8;
    localparam int NP = W * H;
    localparam int AW = $clog2(NP);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cfg_channel;
    logic [3:0] cfg_threshold;
    logic       sync_err;
    logic [11:0] img [NP];
    int total = 0;
    int bad = 0;
    int serr = 0;

    always #10 clk = ~clk;

    colour_centroid_tracker_if #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) bus ();

`ifdef CENTROID_BBOX_EN
    logic [4:0] bxmin, bxmax;
    logic [2:0] bymin, bymax;
`endif

    colour_centroid_tracker #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .cfg_channel   (cfg_channel),
        .cfg_threshold (cfg_threshold),
        .sync_err      (sync_err)
`ifdef CENTROID_BBOX_EN
        ,
        .bbox_xmin     (bxmin),
        .bbox_xmax     (bxmax),
        .bbox_ymin     (bymin),
        .bbox_ymax     (bymax)
`endif
    );

    always @(negedge clk) if (sync_err === 1'b1) serr++;

    task automatic clear_img;
        for (int i = 0; i < NP; i++) img[i] = 12'h000;
    endtask

    task automatic drive_frame(input int gap, input int skip,
                               input int mid_at, input logic [1:0] mid_ch);
        for (int a = 0; a < NP; a++) begin
            if (a == mid_at) cfg_channel = mid_ch;
            if (gap > 0 && a % gap == 0) begin
                @(negedge clk);
                bus.pix_valid = 1'b0;
            end
            @(negedge clk);
            if (a == skip) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_addr  = AW'(a);
                bus.pix_data  = img[a];
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        for (int i = 0; i < n; i++) begin
            if (bus.res_valid === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic ack;
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.res_valid); end
        total++; if (bus.heading !== 6'h3f) begin bad++; $display("FAIL rst_heading got=%0d want=-1", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'h3f) begin bad++; $display("FAIL rst_elev got=%0d want=-1", $signed(bus.elevation)); end
        total++; if (bus.pix_count !== 9'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.pix_count); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b want=0", bus.overrun); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_syncerr got=%b want=0", sync_err); end
        rst_n = 1'b1;
        // Partial red frame, then reset: nothing of it may survive.
        for (int a = 0; a < 10; a++) begin
            @(negedge clk);
            bus.pix_valid = 1'b1;
            bus.pix_addr  = AW'(a);
            bus.pix_data  = 12'hF00;
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_black;
        clear_img();
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL black_valid got=%b want=1", bus.res_valid); end
        total++; if (bus.heading !== 6'h3f) begin bad++; $display("FAIL black_heading got=%0d want=-1", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'h3f) begin bad++; $display("FAIL black_elev got=%0d want=-1", $signed(bus.elevation)); end
        total++; if (bus.pix_count !== 9'd0) begin bad++; $display("FAIL black_count got=%0d want=0", bus.pix_count); end
        ack();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL black_ack got=%b want=0", bus.res_valid); end
        repeat (100) @(negedge clk);
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL black_once got=%b want=0", bus.res_valid); end
    endtask

    task automatic test_single;
        clear_img();
        img[0] = 12'hF00;
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL a0_valid got=%b want=1", bus.res_valid); end
        total++; if (bus.heading !== 6'd0) begin bad++; $display("FAIL a0_heading got=%0d want=0", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd0) begin bad++; $display("FAIL a0_elev got=%0d want=0", $signed(bus.elevation)); end
        total++; if (bus.pix_count !== 9'd1) begin bad++; $display("FAIL a0_count got=%0d want=1", bus.pix_count); end
        ack();
        clear_img();
        img[31] = 12'hF00;
        drive_frame(7, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.heading !== 6'd25) begin bad++; $display("FAIL a31_heading got=%0d want=25", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd0) begin bad++; $display("FAIL a31_elev got=%0d want=0", $signed(bus.elevation)); end
        ack();
        clear_img();
        img[NP-1] = 12'hF00;
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.heading !== 6'd25) begin bad++; $display("FAIL alast_heading got=%0d want=25", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd19) begin bad++; $display("FAIL alast_elev got=%0d want=19", $signed(bus.elevation)); end
        total++; if (bus.pix_count !== 9'd1) begin bad++; $display("FAIL alast_count got=%0d want=1", bus.pix_count); end
        ack();
    endtask

    task automatic test_two;
        clear_img();
        img[12]  = 12'hF00;
        img[184] = 12'hF00;
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.heading !== 6'd14) begin bad++; $display("FAIL two_heading got=%0d want=14", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd5) begin bad++; $display("FAIL two_elev got=%0d want=5", $signed(bus.elevation)); end
        total++; if (bus.pix_count !== 9'd2) begin bad++; $display("FAIL two_count got=%0d want=2", bus.pix_count); end
        ack();
    endtask

    task automatic test_channel;
        clear_img();
        img[3]   = 12'h0F0;
        img[10]  = 12'h0F8;
        img[100] = 12'hF00;
        cfg_channel   = 2'd1;
        cfg_threshold = 4'd8;
        drive_frame(0, -1, 50, 2'd0);
        wait_res(200);
        total++; if (bus.pix_count !== 9'd1) begin bad++; $display("FAIL g_count got=%0d want=1", bus.pix_count); end
        total++; if (bus.heading !== 6'd2) begin bad++; $display("FAIL g_heading got=%0d want=2", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd0) begin bad++; $display("FAIL g_elev got=%0d want=0", $signed(bus.elevation)); end
        ack();
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.pix_count !== 9'd1) begin bad++; $display("FAIL r8_count got=%0d want=1", bus.pix_count); end
        total++; if (bus.heading !== 6'd3) begin bad++; $display("FAIL r8_heading got=%0d want=3", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd8) begin bad++; $display("FAIL r8_elev got=%0d want=8", $signed(bus.elevation)); end
        ack();
        clear_img();
        img[64]  = 12'h400;
        img[70]  = 12'h530;
        img[200] = 12'hFF0;
        cfg_channel   = 2'd3;
        cfg_threshold = 4'd4;
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.pix_count !== 9'd1) begin bad++; $display("FAIL edge_count got=%0d want=1", bus.pix_count); end
        total++; if (bus.heading !== 6'd0) begin bad++; $display("FAIL edge_heading got=%0d want=0", $signed(bus.heading)); end
        total++; if (bus.elevation !== 6'd5) begin bad++; $display("FAIL edge_elev got=%0d want=5", $signed(bus.elevation)); end
        ack();
    endtask

    task automatic test_sync;
        int s0;
        cfg_channel   = 2'd0;
        cfg_threshold = 4'd4;
        clear_img();
        img[0] = 12'hF00;
        s0 = serr;
        drive_frame(0, 100, -1, 2'd0);
        total++; if (serr - s0 !== 1) begin bad++; $display("FAIL skip_pulses got=%0d want=1", serr - s0); end
        repeat (150) @(negedge clk);
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL skip_nores got=%b want=0", bus.res_valid); end
        s0 = serr;
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL resync_valid got=%b want=1", bus.res_valid); end
        total++; if (bus.pix_count !== 9'd1) begin bad++; $display("FAIL resync_count got=%0d want=1", bus.pix_count); end
        total++; if (serr - s0 !== 0) begin bad++; $display("FAIL clean_pulses got=%0d want=0", serr - s0); end
        ack();
    endtask

    task automatic test_overrun;
        clear_img();
        img[31] = 12'hF00;
        drive_frame(0, -1, -1, 2'd0);
        wait_res(200);
        total++; if (bus.heading !== 6'd25) begin bad++; $display("FAIL ovA_heading got=%0d want=25", $signed(bus.heading)); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovA_overrun got=%b want=0", bus.overrun); end
        clear_img();
        img[0] = 12'hF00;
        img[1] = 12'hF00;
        drive_frame(0, -1, -1, 2'd0);
        repeat (150) @(negedge clk);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL ovB_valid got=%b want=1", bus.res_valid); end
        total++; if (bus.heading !== 6'd0) begin bad++; $display("FAIL ovB_heading got=%0d want=0", $signed(bus.heading)); end
        total++; if (bus.pix_count !== 9'd2) begin bad++; $display("FAIL ovB_count got=%0d want=2", bus.pix_count); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovB_overrun got=%b want=1", bus.overrun); end
        ack();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL ov_ack_valid got=%b want=0", bus.res_valid); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ov_ack_overrun got=%b want=0", bus.overrun); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        cfg_channel   = 2'd0;
        cfg_threshold = 4'd4;
        bus.pix_valid = 1'b0;
        bus.pix_addr  = '0;
        bus.pix_data  = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_black();
        test_single();
        test_two();
        test_channel();
        test_sync();
        test_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
